// File: rtl/prod_accum_if.sv
// Product-stream / result bus for prod_accum.
//   in_valid/in_ready/in_prod/in_last   : upstream product stream
//   out_valid/out_ready/out_sum/out_cnt/out_ovf : closed-frame result
// master modport = upstream producer plus downstream consumer; slave = prod_accum.
interface prod_accum_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned CW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_cnt;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/prod_accum.sv
// prod_accum: sums an unsigned product stream into frames. A frame closes on
// in_last or after MAX_TERMS products; the result (sum, term count, overflow)
// is held until the consumer takes it via out_valid/out_ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous frame abort (also discards a pending result)
//   bus  - prod_accum_if.slave: product stream in, result out
module prod_accum #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned MAX_TERMS = 16,
  parameter int unsigned SAT       = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  prod_accum_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_TERMS + 1);
  localparam int unsigned SW = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ovalid_q, ovalid_d;
  logic [ACC_W-1:0] osum_q, osum_d;
  logic [CW-1:0]    ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;

  logic             accept;
  logic [SW-1:0]    sum_w;
  logic             ovf_nxt;
  logic [ACC_W-1:0] acc_res;
  logic [CW-1:0]    cnt_inc;
  logic             close;

  // Ready is a pure function of state; forced low while reset is asserted.
  assign bus.in_ready  = (state_q != HOLD) && !rst;
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = ovalid_q;
  assign bus.out_sum   = osum_q;
  assign bus.out_cnt   = ocnt_q;
  assign bus.out_ovf   = oovf_q;

  // Accumulate datapath: one extra bit captures the carry; overflow is sticky per frame.
  always_comb begin
    sum_w   = {1'b0, acc_q} + SW'(bus.in_prod);
    ovf_nxt = ovf_q | sum_w[ACC_W];
    acc_res = ((SAT != 0) && ovf_nxt) ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];
    cnt_inc = cnt_q + CW'(1);
    close   = bus.in_last || (cnt_inc == CW'(MAX_TERMS));
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ovalid_d = ovalid_q;
    osum_d   = osum_q;
    ocnt_d   = ocnt_q;
    oovf_d   = oovf_q;

    if (clr) begin
      // Abort wins over accept and handshake; last result values stay visible.
      state_d  = IDLE;
      acc_d    = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      ovalid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            if (close) begin
              osum_d   = acc_res;
              ocnt_d   = cnt_inc;
              oovf_d   = ovf_nxt;
              ovalid_d = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
              ovf_d    = 1'b0;
              state_d  = HOLD;
            end else begin
              acc_d    = acc_res;
              cnt_d    = cnt_inc;
              ovf_d    = ovf_nxt;
              state_d  = ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            ovalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ovalid_q <= 1'b0;
      osum_q   <= '0;
      ocnt_q   <= '0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ovalid_q <= ovalid_d;
      osum_q   <= osum_d;
      ocnt_q   <= ocnt_d;
      oovf_q   <= oovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: default 16-bit instance plus two 10-bit
// instances (saturating and wrapping) sharing one stimulus stream.
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prod_accum_if #(.IN_W(8), .ACC_W(16), .CW(5)) bm ();
  prod_accum_if #(.IN_W(8), .ACC_W(10), .CW(5)) bs ();
  prod_accum_if #(.IN_W(8), .ACC_W(10), .CW(5)) bw ();

  logic       t3_valid = 1'b0;
  logic [7:0] t3_prod  = 8'h00;
  logic       t3_last  = 1'b0;

  assign bs.in_valid  = t3_valid;
  assign bs.in_prod   = t3_prod;
  assign bs.in_last   = t3_last;
  assign bs.out_ready = 1'b1;
  assign bw.in_valid  = t3_valid;
  assign bw.in_prod   = t3_prod;
  assign bw.in_last   = t3_last;
  assign bw.out_ready = 1'b1;

  prod_accum #(.IN_W(8), .ACC_W(16), .MAX_TERMS(16), .SAT(1)) u_main (
    .clk(clk), .rst(rst), .clr(clr), .bus(bm));
  prod_accum #(.IN_W(8), .ACC_W(10), .MAX_TERMS(16), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .bus(bs));
  prod_accum #(.IN_W(8), .ACC_W(10), .MAX_TERMS(16), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .bus(bw));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product on the main DUT and hold it until accepted.
  task automatic send(input logic [7:0] p, input logic l);
    int n;
    n = 0;
    bm.in_valid = 1'b1;
    bm.in_prod  = p;
    bm.in_last  = l;
    while (!bm.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    tick();
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
  endtask

  initial begin
    bm.in_valid  = 1'b0;
    bm.in_prod   = 8'h00;
    bm.in_last   = 1'b0;
    bm.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_in_ready",  32'(bm.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bm.out_valid), 32'd0);
    chk("rst_out_sum",   32'(bm.out_sum),   32'd0);
    chk("rst_out_cnt",   32'(bm.out_cnt),   32'd0);
    chk("rst_out_ovf",   32'(bm.out_ovf),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(bm.in_ready), 32'd1);

    // 10-bit overflow: five 0xFF, last on the fifth
    for (int i = 0; i < 5; i++) begin
      t3_valid = 1'b1;
      t3_prod  = 8'hFF;
      t3_last  = (i == 4);
      chk("t3_ready", 32'(bs.in_ready), 32'd1);
      tick();
    end
    t3_valid = 1'b0;
    t3_last  = 1'b0;
    chk("t3_sat_valid", 32'(bs.out_valid), 32'd1);
    chk("t3_sat_sum",   32'(bs.out_sum),   32'h3FF);
    chk("t3_sat_ovf",   32'(bs.out_ovf),   32'd1);
    chk("t3_sat_cnt",   32'(bs.out_cnt),   32'd5);
    chk("t3_wrap_sum",  32'(bw.out_sum),   32'h0FB);
    chk("t3_wrap_ovf",  32'(bw.out_ovf),   32'd1);
    tick();
    // Overflow flag must not leak into the next frame
    t3_valid = 1'b1;
    t3_prod  = 8'h01;
    t3_last  = 1'b1;
    tick();
    t3_valid = 1'b0;
    t3_last  = 1'b0;
    chk("t3_next_sum", 32'(bs.out_sum), 32'h001);
    chk("t3_next_ovf", 32'(bs.out_ovf), 32'd0);
    tick();

    // Basic three-term frame
    send(8'h0F, 1'b0);
    send(8'h0E, 1'b0);
    send(8'h2D, 1'b1);
    chk("t1_valid", 32'(bm.out_valid), 32'd1);
    chk("t1_sum",   32'(bm.out_sum),   32'h004A);
    chk("t1_cnt",   32'(bm.out_cnt),   32'd3);
    chk("t1_ovf",   32'(bm.out_ovf),   32'd0);
    chk("t1_ready_low", 32'(bm.in_ready), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(bm.out_valid), 32'd0);
    chk("t1_ready_back", 32'(bm.in_ready),  32'd1);

    // Auto-close after 16 terms
    for (int i = 0; i < 16; i++) send(8'h01, 1'b0);
    chk("t2_valid", 32'(bm.out_valid), 32'd1);
    chk("t2_sum",   32'(bm.out_sum),   32'h0010);
    chk("t2_cnt",   32'(bm.out_cnt),   32'd16);
    tick();
    send(8'h05, 1'b1);
    chk("t2_new_sum", 32'(bm.out_sum), 32'h0005);
    chk("t2_new_cnt", 32'(bm.out_cnt), 32'd1);
    tick();

    // Backpressure
    bm.out_ready = 1'b0;
    send(8'h07, 1'b0);
    send(8'h08, 1'b1);
    chk("t4_valid", 32'(bm.out_valid), 32'd1);
    bm.in_valid = 1'b1;
    bm.in_prod  = 8'h20;
    bm.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(bm.out_valid), 32'd1);
      chk("t4_hold_sum",   32'(bm.out_sum),   32'h000F);
      chk("t4_hold_ready", 32'(bm.in_ready),  32'd0);
    end
    bm.out_ready = 1'b1;
    tick();
    chk("t4_hs_valid", 32'(bm.out_valid), 32'd0);
    chk("t4_hs_ready", 32'(bm.in_ready),  32'd1);
    tick();
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    chk("t4_next_valid", 32'(bm.out_valid), 32'd1);
    chk("t4_next_sum",   32'(bm.out_sum),   32'h0020);
    chk("t4_next_cnt",   32'(bm.out_cnt),   32'd1);
    tick();

    // Async reset mid-frame
    send(8'h09, 1'b0);
    send(8'h0C, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_sum_zero",  32'(bm.out_sum),   32'd0);
    chk("t5_cnt_zero",  32'(bm.out_cnt),   32'd0);
    chk("t5_valid",     32'(bm.out_valid), 32'd0);
    chk("t5_ready_low", 32'(bm.in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(8'h03, 1'b1);
    chk("t5_new_valid", 32'(bm.out_valid), 32'd1);
    chk("t5_new_sum",   32'(bm.out_sum),   32'h0003);
    chk("t5_new_cnt",   32'(bm.out_cnt),   32'd1);
    tick();

    // clr coincident with a closing accept
    send(8'h04, 1'b0);
    bm.in_valid = 1'b1;
    bm.in_prod  = 8'h05;
    bm.in_last  = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bm.in_valid = 1'b0;
    bm.in_last  = 1'b0;
    chk("t6_no_valid", 32'(bm.out_valid), 32'd0);
    chk("t6_ready",    32'(bm.in_ready),  32'd1);
    send(8'h06, 1'b1);
    chk("t6_new_valid", 32'(bm.out_valid), 32'd1);
    chk("t6_new_sum",   32'(bm.out_sum),   32'h0006);
    chk("t6_new_cnt",   32'(bm.out_cnt),   32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
